// File: rtl/sram_port1_reader.sv
// Streams a block of words out of SRAM port 1 onto a ready/valid interface.
// A command (base address, word count) is taken when idle; reads are issued
// only while the 2-entry output FIFO has room, so no returned word is lost.
// SRAM port 1 is treated as returning dout1_i for the address presented in
// the issue cycle, registered into the FIFO at the closing edge of that cycle.
// Optional feature: define SRAM_RD_CSUM_EN to add the csum_o running checksum.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start_i; addr1_o holds the last issued address
// S_READ  | issuing reads whenever the FIFO has a free slot
// S_DRAIN | all reads issued; waiting for the last beat to be accepted
module sram_port1_reader (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [8:0]  base_addr_i,
    input  logic [9:0]  len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        csb1_o,
    output logic [8:0]  addr1_o,
    input  logic [31:0] dout1_i,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [31:0] m_data_o,
    output logic        m_last_o
`ifdef SRAM_RD_CSUM_EN
    ,
    output logic [31:0] csum_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [9:0]  len_clamped;
    logic        start_ok;
    logic        start_nop;
    logic        issue;
    logic        last_issue;
    logic        pop;
    logic [9:0]  rd_left_q;
    logic [8:0]  rd_addr_q;
    logic        done_q;
    logic [1:0]  fifo_cnt_q;
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [31:0] fifo_data_q [2];
    logic [1:0]  fifo_last_q;

    assign len_clamped = (len_i > 10'd512) ? 10'd512 : len_i;
    assign start_ok    = (state_q == S_IDLE) && start_i && (len_clamped != 10'd0);
    assign start_nop   = (state_q == S_IDLE) && start_i && (len_clamped == 10'd0);
    assign last_issue  = issue && (rd_left_q == 10'd1);
    assign pop         = m_valid_o && m_ready_i;

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;
    assign addr1_o   = rd_addr_q;
    assign m_valid_o = (fifo_cnt_q != 2'd0);
    assign m_data_o  = fifo_data_q[rd_ptr_q];
    assign m_last_o  = fifo_last_q[rd_ptr_q];

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state and read issue; a read goes out only if the FIFO can take it
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        csb1_o  = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_READ;
            end
            S_READ: begin
                issue  = (fifo_cnt_q < 2'd2);
                csb1_o = ~issue;
                if (issue && (rd_left_q == 10'd1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && m_last_o) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command capture, read address/count tracking and the done pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_addr_q <= 9'd0;
            rd_left_q <= 10'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= start_nop || ((state_q == S_DRAIN) && pop && m_last_o);
            if (start_ok) begin
                rd_addr_q <= base_addr_i;
                rd_left_q <= len_clamped;
            end else if (issue) begin
                rd_left_q <= rd_left_q - 10'd1;
                // The final address stays on addr1_o after the command
                if (!last_issue) rd_addr_q <= rd_addr_q + 9'd1;
            end
        end
    end

    // Two-entry output FIFO; each entry carries its end-of-command flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_data_q[0] <= 32'd0;
            fifo_data_q[1] <= 32'd0;
            fifo_last_q    <= 2'b00;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            if (issue) begin
                fifo_data_q[wr_ptr_q] <= dout1_i;
                fifo_last_q[wr_ptr_q] <= last_issue;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({issue, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

`ifdef SRAM_RD_CSUM_EN
    logic [31:0] csum_q;
    assign csum_o = csum_q;

    // Running sum of accepted beats, cleared by every start taken in idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                           csum_q <= 32'd0;
        else if (start_i && state_q == S_IDLE) csum_q <= 32'd0;
        else if (pop)                          csum_q <= csum_q + m_data_o;
    end
`endif

endmodule

// File: tb/tb_sram_port1_reader.sv
module tb_sram_port1_reader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [8:0]  base_addr_i;
    logic [9:0]  len_i;
    logic        busy_o, done_o, csb1_o;
    logic [8:0]  addr1_o;
    logic [31:0] dout1_i;
    logic        m_valid_o, m_ready_i, m_last_o;
    logic [31:0] m_data_o;
`ifdef SRAM_RD_CSUM_EN
    logic [31:0] csum_o;
`endif

    logic [31:0] mem [512];
    assign dout1_i = mem[addr1_o];

    always #5 clk_i = ~clk_i;

    sram_port1_reader dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .base_addr_i(base_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .csb1_o(csb1_o), .addr1_o(addr1_o),
        .dout1_i(dout1_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_data_o(m_data_o), .m_last_o(m_last_o)
`ifdef SRAM_RD_CSUM_EN
        , .csum_o(csum_o)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: command queue of expected beats, issue/accept counters
    int          cyc = 0;
    bit          mdl_busy, mdl_done, prev_stall, prev_last;
    int          reads_left, issued, accepted;
    logic [8:0]  next_addr;
    logic [31:0] exp_csum, prev_data;
    logic [31:0] exp_data [$];
    bit          exp_last [$];
    // Observation logs (from the DUT) for the directed literal checks
    logic [31:0] beat_log [$];
    bit          last_log [$];
    logic [8:0]  addr_log [$];
    int          csb_low_cnt, done_cnt, busy_seen, dut_issued, dut_acc, max_out;
    int          start_cyc, first_valid_cyc;

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        int occ, len_c;
        bit cur_busy, exp_csb;
        if (!rst_ni) begin
            mdl_busy = 0; mdl_done = 0; reads_left = 0; issued = 0; accepted = 0;
            exp_csum = 0; prev_stall = 0;
            exp_data.delete(); exp_last.delete();
        end else begin
            occ      = issued - accepted;
            cur_busy = mdl_busy;
            exp_csb  = !(mdl_busy && reads_left > 0 && occ < 2);
            chk("busy", 32'(busy_o), 32'(mdl_busy));
            chk("done", 32'(done_o), 32'(mdl_done));
            chk("m_valid", 32'(m_valid_o), 32'(occ > 0));
            chk("csb1", 32'(csb1_o), 32'(exp_csb));
            if (!csb1_o) chk("addr1", 32'(addr1_o), 32'(next_addr));
            if (m_valid_o && exp_data.size() > 0) begin
                chk("m_data", m_data_o, exp_data[0]);
                chk("m_last", 32'(m_last_o), 32'(exp_last[0]));
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid_o), 32'd1);
                chk("stall_data", m_data_o, prev_data);
                chk("stall_last", 32'(m_last_o), 32'(prev_last));
            end
`ifdef SRAM_RD_CSUM_EN
            chk("csum", csum_o, exp_csum);
`endif
            // DUT observation logs
            if (done_o) done_cnt++;
            if (busy_o) busy_seen++;
            if (!csb1_o) begin
                if (dut_issued - dut_acc > max_out) max_out = dut_issued - dut_acc;
                csb_low_cnt++; dut_issued++; addr_log.push_back(addr1_o);
            end
            if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid_o && m_ready_i) begin
                beat_log.push_back(m_data_o); last_log.push_back(m_last_o); dut_acc++;
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
            // Model advance across the coming rising edge
            mdl_done = 0;
            if (!exp_csb) begin
                issued++; reads_left--; next_addr = next_addr + 9'd1;
            end
            if (occ > 0 && m_ready_i && exp_data.size() > 0) begin
                accepted++;
                exp_csum = exp_csum + exp_data[0];
                if (exp_last[0]) begin mdl_busy = 0; mdl_done = 1; end
                void'(exp_data.pop_front()); void'(exp_last.pop_front());
            end
            if (start_i && !cur_busy) begin
                len_c = (int'(len_i) > 512) ? 512 : int'(len_i);
                exp_csum = 0;
                if (len_c == 0) mdl_done = 1;
                else begin
                    mdl_busy = 1; reads_left = len_c; issued = 0; accepted = 0;
                    next_addr = base_addr_i; start_cyc = cyc;
                    for (int i = 0; i < len_c; i++) begin
                        exp_data.push_back(mem[(int'(base_addr_i) + i) % 512]);
                        exp_last.push_back(i == len_c - 1);
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        beat_log.delete(); last_log.delete(); addr_log.delete();
        csb_low_cnt = 0; done_cnt = 0; busy_seen = 0;
        dut_issued = 0; dut_acc = 0; max_out = 0; first_valid_cyc = -1;
    endtask

    task automatic start_cmd(input logic [8:0] b, input logic [9:0] l);
        @(posedge clk_i); #1;
        clear_logs();
        start_i = 1; base_addr_i = b; len_i = l;
        @(posedge clk_i); #1;
        start_i = 0;
    endtask

    task automatic wait_done(input int budget, input bit toggle, output int waited);
        waited = -1;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin waited = i; break; end
            @(posedge clk_i); #1;
            if (toggle) m_ready_i = ~m_ready_i;
        end
        if (waited < 0) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: no done_o within %0d cycles", budget);
        end
        m_ready_i = 1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_csb1"}, 32'(csb1_o), 32'd1);
        chk({tag, "_addr1"}, 32'(addr1_o), 32'd0);
        chk({tag, "_valid"}, 32'(m_valid_o), 32'd0);
        chk({tag, "_last"}, 32'(m_last_o), 32'd0);
        chk({tag, "_data"}, m_data_o, 32'd0);
`ifdef SRAM_RD_CSUM_EN
        chk({tag, "_csum"}, csum_o, 32'd0);
`endif
    endtask

    initial begin
        int w, lasts;
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 + i;
        mem[10] = 32'd1; mem[11] = 32'd2; mem[12] = 32'd3; mem[13] = 32'd4;
        rst_ni = 0; start_i = 0; base_addr_i = 0; len_i = 0; m_ready_i = 1;
        clear_logs();
        repeat (3) @(posedge clk_i);
        #1 chk_reset_outputs("reset");
        rst_ni = 1;

        // Basic 4-word read
        start_cmd(9'd10, 10'd4);
        wait_done(50, 0, w);
        chk("b1_beats", 32'(beat_log.size()), 32'd4);
        if (beat_log.size() == 4) begin
            chk("b1_d0", beat_log[0], 32'd1);
            chk("b1_d1", beat_log[1], 32'd2);
            chk("b1_d2", beat_log[2], 32'd3);
            chk("b1_d3", beat_log[3], 32'd4);
            lasts = 0;
            foreach (last_log[i]) lasts += int'(last_log[i]);
            chk("b1_last_cnt", 32'(lasts), 32'd1);
            chk("b1_last_pos", 32'(last_log[3]), 32'd1);
        end
        chk("b1_latency", 32'(first_valid_cyc - start_cyc), 32'd2);
        chk("b1_busy_at_done", 32'(busy_o), 32'd0);
`ifdef SRAM_RD_CSUM_EN
        chk("b1_csum", csum_o, 32'd10);
`endif

        // Address wrap 510 -> 1
        start_cmd(9'd510, 10'd4);
        wait_done(50, 0, w);
        chk("wrap_reads", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            chk("wrap_a0", 32'(addr_log[0]), 32'd510);
            chk("wrap_a1", 32'(addr_log[1]), 32'd511);
            chk("wrap_a2", 32'(addr_log[2]), 32'd0);
            chk("wrap_a3", 32'(addr_log[3]), 32'd1);
        end
        if (beat_log.size() == 4) begin
            chk("wrap_d0", beat_log[0], 32'hA000_01FE);
            chk("wrap_d2", beat_log[2], 32'hA000_0000);
        end
        chk("wrap_idle_addr", 32'(addr1_o), 32'd1);

        // Back-pressure: ready toggles every cycle
        start_cmd(9'd20, 10'd8);
        wait_done(100, 1, w);
        chk("bp_beats", 32'(beat_log.size()), 32'd8);
        chk("bp_max_outstanding", 32'(max_out <= 2), 32'd1);
        if (beat_log.size() == 8) chk("bp_d7", beat_log[7], 32'hA000_001B);

        // Zero-length command
        start_cmd(9'd40, 10'd0);
        wait_done(10, 0, w);
        chk("len0_done_wait", 32'(w), 32'd0);
        chk("len0_reads", 32'(csb_low_cnt), 32'd0);
        chk("len0_busy_seen", 32'(busy_seen), 32'd0);

        // Oversized command clamps to 512
        start_cmd(9'd0, 10'd700);
        wait_done(700, 0, w);
        chk("clamp_beats", 32'(beat_log.size()), 32'd512);
        chk("clamp_reads", 32'(csb_low_cnt), 32'd512);

        // Reset after three beats
        start_cmd(9'd30, 10'd8);
        for (int i = 0; i < 40 && beat_log.size() < 3; i++) begin
            @(posedge clk_i); #1;
        end
        chk("rst_beats_before", 32'(beat_log.size()), 32'd3);
        rst_ni = 0;
        #1 chk_reset_outputs("midrst");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
        repeat (4) @(posedge clk_i);
        #1 chk("midrst_no_done", 32'(done_cnt), 32'd0);
        start_cmd(9'd10, 10'd4);
        wait_done(50, 0, w);
        chk("post_rst_beats", 32'(beat_log.size()), 32'd4);
        if (beat_log.size() == 4) chk("post_rst_d3", beat_log[3], 32'd4);

        // Second start while busy is ignored
        start_cmd(9'd100, 10'd6);
        @(posedge clk_i); #1;
        start_i = 1; base_addr_i = 9'd200; len_i = 10'd3;
        @(posedge clk_i); #1;
        start_i = 0;
        wait_done(60, 0, w);
        chk("ignore_beats", 32'(beat_log.size()), 32'd6);
        if (beat_log.size() == 6) chk("ignore_d5", beat_log[5], 32'hA000_0069);
        repeat (4) @(posedge clk_i);
        #1 chk("ignore_idle_busy", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
